btb_update_unit: RTL and testbench

- Control side of the 32-entry branch target buffer: in Fetch, consumes the BTB read data and forms the predicted next PC.
- Carries each prediction through Decode to Execute in valid-tagged pipeline registers.
- In Execute, resolves the branch against the actual outcome, drives the BTB write port (saturating 2-bit counter update, allocation) and raises mispredict/redirect to the hazard unit.
- Keeps branch and mispredict event counters.

---
 rtl/btb_update_unit.sv | 82 ++++++++
 tb/tb_btb_update_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/btb_update_unit.sv
// btb_update_unit: BTB next-PC prediction in Fetch and branch resolution/BTB update in Execute.
module btb_update_unit #(
    parameter int IDX_W = 5,
    parameter int TAG_W = 27,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [31:0]      pcF_i,
    input  logic [TAG_W-1:0] btb_tagF_i,
    input  logic [31:0]      btb_targetF_i,
    input  logic [1:0]       btb_predF_i,
    input  logic             stallD_i,
    input  logic             stallE_i,
    input  logic             flushD_i,
    input  logic             flushE_i,
    input  logic             branchE_i,
    input  logic             takenE_i,
    input  logic [31:0]      targetE_i,
    output logic [31:0]      pc_predF_o,
    output logic             btb_we_o,
    output logic [IDX_W-1:0] btb_indexE_o,
    output logic [TAG_W-1:0] btb_tagE_o,
    output logic [31:0]      btb_targetE_o,
    output logic [1:0]       btb_predE_o,
    output logic             mispredictE_o,
    output logic [31:0]      redirect_pcE_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);
    logic        hitF, takenF;
    logic        validD_q, hitD_q, takenD_q, validE_q, hitE_q, takenE_q;
    logic [31:0] pcD_q, tgtD_q, pcE_q, tgtE_q;
    logic [1:0]  cntD_q, cntE_q, cnt_inc, cnt_dec;
    logic        act;
    logic [CNT_W-1:0] branch_cnt_d, mispred_cnt_d;

    assign hitF       = btb_tagF_i == pcF_i[31:32-TAG_W];
    assign takenF     = hitF & btb_predF_i[1];
    assign pc_predF_o = takenF ? btb_targetF_i : pcF_i + 32'd4;

    // flush wins over stall: a flushed stage always becomes a bubble
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            validD_q <= 1'b0; hitD_q <= 1'b0; takenD_q <= 1'b0; pcD_q <= '0; tgtD_q <= '0; cntD_q <= '0;
            validE_q <= 1'b0; hitE_q <= 1'b0; takenE_q <= 1'b0; pcE_q <= '0; tgtE_q <= '0; cntE_q <= '0;
            branch_cnt_o <= '0; mispred_cnt_o <= '0;
        end else begin
            if (flushD_i) begin
                validD_q <= 1'b0;
            end else if (!stallD_i) begin
                validD_q <= 1'b1; hitD_q <= hitF; takenD_q <= takenF;
                pcD_q <= pcF_i; tgtD_q <= btb_targetF_i; cntD_q <= btb_predF_i;
            end
            if (flushE_i) begin
                validE_q <= 1'b0;
            end else if (!stallE_i) begin
                validE_q <= validD_q; hitE_q <= hitD_q; takenE_q <= takenD_q;
                pcE_q <= pcD_q; tgtE_q <= tgtD_q; cntE_q <= cntD_q;
            end
            branch_cnt_o  <= branch_cnt_d;
            mispred_cnt_o <= mispred_cnt_d;
        end
    end

    assign act     = validE_q & branchE_i;
    assign cnt_inc = (cntE_q == 2'b11) ? 2'b11 : cntE_q + 2'd1;
    assign cnt_dec = (cntE_q == 2'b00) ? 2'b00 : cntE_q - 2'd1;

    always_comb begin
        btb_we_o       = act & (hitE_q | takenE_i);
        btb_indexE_o   = btb_we_o ? pcE_q[IDX_W+1:2] : '0;
        btb_tagE_o     = btb_we_o ? pcE_q[31:32-TAG_W] : '0;
        btb_targetE_o  = btb_we_o ? (takenE_i ? targetE_i : tgtE_q) : '0;
        btb_predE_o    = !btb_we_o ? 2'b00 : !hitE_q ? 2'b10 : takenE_i ? cnt_inc : cnt_dec;
        mispredictE_o  = act & ((takenE_q != takenE_i) | (takenE_q & takenE_i & (tgtE_q != targetE_i)));
        redirect_pcE_o = !act ? 32'd0 : takenE_i ? targetE_i : pcE_q + 32'd4;
        // a stalled E instruction is counted only on the cycle it leaves E
        branch_cnt_d   = branch_cnt_o + CNT_W'(act & !stallE_i);
        mispred_cnt_d  = mispred_cnt_o + CNT_W'(act & !stallE_i & mispredictE_o);
    end
endmodule

// File: tb/tb_btb_update_unit.sv
// tb_btb_update_unit: directed vectors with hand-computed expectations for btb_update_unit.
module tb_btb_update_unit;
    logic        clk_i = 1'b0, reset_i;
    logic [31:0] pcF_i, btb_targetF_i, targetE_i;
    logic [26:0] btb_tagF_i;
    logic [1:0]  btb_predF_i;
    logic        stallD_i, stallE_i, flushD_i, flushE_i, branchE_i, takenE_i;
    logic [31:0] pc_predF_o, btb_targetE_o, redirect_pcE_o, branch_cnt_o, mispred_cnt_o;
    logic        btb_we_o, mispredictE_o;
    logic [4:0]  btb_indexE_o;
    logic [26:0] btb_tagE_o;
    logic [1:0]  btb_predE_o;
    logic [31:0] last_pred;
    int tests = 0, fails = 0;

    btb_update_unit dut (
        .clk_i(clk_i), .reset_i(reset_i), .pcF_i(pcF_i), .btb_tagF_i(btb_tagF_i),
        .btb_targetF_i(btb_targetF_i), .btb_predF_i(btb_predF_i), .stallD_i(stallD_i),
        .stallE_i(stallE_i), .flushD_i(flushD_i), .flushE_i(flushE_i), .branchE_i(branchE_i),
        .takenE_i(takenE_i), .targetE_i(targetE_i), .pc_predF_o(pc_predF_o), .btb_we_o(btb_we_o),
        .btb_indexE_o(btb_indexE_o), .btb_tagE_o(btb_tagE_o), .btb_targetE_o(btb_targetE_o),
        .btb_predE_o(btb_predE_o), .mispredictE_o(mispredictE_o), .redirect_pcE_o(redirect_pcE_o),
        .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    // fetch a branch, push a filler behind it, then present its outcome in E
    task automatic run_branch(input logic [31:0] pc, input logic hit, input logic [1:0] ctr,
                              input logic [31:0] ptgt, input logic tk, input logic [31:0] atgt);
        pcF_i = pc; btb_tagF_i = hit ? pc[31:5] : ~pc[31:5]; btb_predF_i = ctr; btb_targetF_i = ptgt;
        branchE_i = 1'b0;
        #1 last_pred = pc_predF_o;
        step;
        pcF_i = 32'h1000; btb_tagF_i = '0; btb_predF_i = 2'b00; btb_targetF_i = '0;
        step;
        branchE_i = 1'b1; takenE_i = tk; targetE_i = atgt;
        #1;
    endtask

    task automatic retire;
        step;
        branchE_i = 1'b0; takenE_i = 1'b0; targetE_i = '0;
        #1;
    endtask

    initial begin
        reset_i = 1'b1; pcF_i = 32'h100; btb_tagF_i = 27'd1; btb_targetF_i = 32'h500; btb_predF_i = 2'b11;
        stallD_i = 0; stallE_i = 0; flushD_i = 0; flushE_i = 0; branchE_i = 0; takenE_i = 0; targetE_i = 0;
        #3;
        chk("rst_pcpred", pc_predF_o, 32'h104);
        chk("rst_bcnt", branch_cnt_o, 0);
        chk("rst_we", {31'd0, btb_we_o}, 0);
        chk("rst_mis", {31'd0, mispredictE_o}, 0);
        @(negedge clk_i) reset_i = 1'b0;
        step;

        run_branch(32'h200, 0, 2'b11, 32'h500, 1, 32'h300);
        chk("miss_fetch", last_pred, 32'h204);
        chk("miss_we", {31'd0, btb_we_o}, 1);
        chk("miss_pred", {30'd0, btb_predE_o}, 2'b10);
        chk("miss_tgt", btb_targetE_o, 32'h300);
        chk("miss_idx", {27'd0, btb_indexE_o}, 0);
        chk("miss_tag", {5'd0, btb_tagE_o}, 32'h10);
        chk("miss_mis", {31'd0, mispredictE_o}, 1);
        chk("miss_redir", redirect_pcE_o, 32'h300);
        retire;
        chk("miss_bcnt", branch_cnt_o, 1);
        chk("miss_mcnt", mispred_cnt_o, 1);

        run_branch(32'h200, 1, 2'b11, 32'h300, 1, 32'h300);
        chk("sat3_fetch", last_pred, 32'h300);
        chk("sat3_pred", {30'd0, btb_predE_o}, 2'b11);
        chk("sat3_mis", {31'd0, mispredictE_o}, 0);
        retire;

        run_branch(32'h200, 1, 2'b00, 32'h300, 0, 32'h0);
        chk("sat0_fetch", last_pred, 32'h204);
        chk("sat0_we", {31'd0, btb_we_o}, 1);
        chk("sat0_pred", {30'd0, btb_predE_o}, 2'b00);
        chk("sat0_tgt", btb_targetE_o, 32'h300);
        chk("sat0_redir", redirect_pcE_o, 32'h204);
        retire;
        chk("sat0_bcnt", branch_cnt_o, 3);
        chk("sat0_mcnt", mispred_cnt_o, 1);

        run_branch(32'h200, 1, 2'b10, 32'h300, 0, 32'h0);
        chk("wt_pred", {30'd0, btb_predE_o}, 2'b01);
        chk("wt_mis", {31'd0, mispredictE_o}, 1);
        chk("wt_redir", redirect_pcE_o, 32'h204);
        retire;
        chk("wt_mcnt", mispred_cnt_o, 2);

        run_branch(32'h244, 1, 2'b11, 32'h300, 1, 32'h400);
        chk("tgt_mis", {31'd0, mispredictE_o}, 1);
        chk("tgt_tgt", btb_targetE_o, 32'h400);
        chk("tgt_idx", {27'd0, btb_indexE_o}, 32'h11);
        retire;

        run_branch(32'h200, 0, 2'b00, 32'h0, 0, 32'h0);
        chk("mnt_we", {31'd0, btb_we_o}, 0);
        chk("mnt_mis", {31'd0, mispredictE_o}, 0);
        chk("mnt_redir", redirect_pcE_o, 32'h204);
        retire;
        chk("mnt_bcnt", branch_cnt_o, 6);
        chk("mnt_mcnt", mispred_cnt_o, 3);

        pcF_i = 32'h200; btb_tagF_i = 27'd0;
        step;
        pcF_i = 32'h1000; flushE_i = 1; stallE_i = 1;
        step;
        flushE_i = 0; stallE_i = 0; branchE_i = 1; takenE_i = 1; targetE_i = 32'h300;
        #1;
        chk("flush_we", {31'd0, btb_we_o}, 0);
        chk("flush_mis", {31'd0, mispredictE_o}, 0);
        retire;
        chk("flush_bcnt", branch_cnt_o, 6);

        run_branch(32'h200, 0, 2'b00, 32'h0, 1, 32'h300);
        stallE_i = 1;
        for (int i = 0; i < 3; i++) step;
        chk("stall_we", {31'd0, btb_we_o}, 1);
        chk("stall_hold", branch_cnt_o, 6);
        stallE_i = 0;
        retire;
        chk("stall_bcnt", branch_cnt_o, 7);
        chk("stall_mcnt", mispred_cnt_o, 4);

        run_branch(32'h200, 0, 2'b00, 32'h0, 1, 32'h300);
        reset_i = 1;
        #1;
        chk("arst_we", {31'd0, btb_we_o}, 0);
        chk("arst_bcnt", branch_cnt_o, 0);
        chk("arst_redir", redirect_pcE_o, 0);
        reset_i = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
